// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: CP0 register numbers, exception codes and SR/Cause field positions.
package cp0_unit_pkg;
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;
  localparam logic [4:0] EXC_INT   = 5'd0;
  localparam logic [4:0] EXC_ADEL  = 5'd4;
  localparam logic [4:0] EXC_ADES  = 5'd5;
  localparam logic [4:0] EXC_RI    = 5'd10;
  localparam logic [4:0] EXC_OV    = 5'd12;
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;
endpackage

// File: rtl/cp0_unit.sv
// cp0_unit: M-stage coprocessor 0 (SR/Cause/EPC/PRId, mtc0/mfc0/eret, interrupt/exception arbitration).
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2019_0701,
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic [31:0] exc_vec,
  output logic        int_req
);
  logic [5:0] im_q, im_d, ip_q;
  logic exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, irq, exc;
  logic [4:0] exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d, sr, cause, pc_al;
  logic unused_pc;
  assign unused_pc = ^pc_m[1:0];
  assign epc_out = epc_q;
  assign exc_vec = EXC_VEC;
  always_comb begin
    sr = {16'b0, im_q, 8'b0, exl_q, ie_q};
    cause = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
    irq = |(hw_int & im_q) & ie_q & ~exl_q & valid_m;
    exc = (exc_code_m != EXC_INT) & ~exl_q & valid_m;
    int_req = irq | exc;
    cp0_rdata = cp0_addr == REG_SR ? sr : cp0_addr == REG_CAUSE ? cause :
                cp0_addr == REG_EPC ? epc_q : cp0_addr == REG_PRID ? PRID : 32'd0;
    pc_al = {pc_m[31:2], 2'b00};
    im_d = im_q;
    exl_d = exl_q;
    ie_d = ie_q;
    bd_d = bd_q;
    exc_code_d = exc_code_q;
    epc_d = epc_q;
    // Entry discards the M-stage instruction, so its mtc0/eret must not land.
    if (int_req) begin
      exl_d = 1'b1;
      exc_code_d = irq ? EXC_INT : exc_code_m;
      bd_d = bd_m;
      epc_d = bd_m ? pc_al - 32'd4 : pc_al;
    end else begin
      if (cp0_we && cp0_addr == REG_SR) begin
        im_d = cp0_wdata[SR_IM_HI:SR_IM_LO];
        exl_d = cp0_wdata[SR_EXL];
        ie_d = cp0_wdata[SR_IE];
      end
      if (cp0_we && cp0_addr == REG_EPC) epc_d = {cp0_wdata[31:2], 2'b00};
      if (eret_m) exl_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q <= '0;
      exl_q <= 1'b0;
      ie_q <= 1'b0;
      bd_q <= 1'b0;
      ip_q <= '0;
      exc_code_q <= '0;
      epc_q <= '0;
    end else begin
      im_q <= im_d;
      exl_q <= exl_d;
      ie_q <= ie_d;
      bd_q <= bd_d;
      ip_q <= hw_int;
      exc_code_q <= exc_code_d;
      epc_q <= epc_d;
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scoreboard bench for cp0_unit; expectations queued at stimulus, compared against captured outputs.
`timescale 1ns/1ps
module tb_cp0_unit;
  typedef struct {
    string       n;
    logic [31:0] v;
  } ent_t;
  logic clk = 1'b0, reset = 1'b1, valid_m = 1'b0, bd_m = 1'b0, cp0_we = 1'b0, eret_m = 1'b0;
  logic [31:0] pc_m = '0, cp0_wdata = '0;
  logic [4:0] exc_code_m = '0, cp0_addr = '0;
  logic [5:0] hw_int = '0;
  logic [31:0] cp0_rdata, epc_out, exc_vec;
  logic int_req;
  ent_t want_q[$], got_q[$];
  ent_t e, o;
  int tests = 0, fails = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
    .exc_code_m(exc_code_m), .hw_int(hw_int), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .eret_m(eret_m), .cp0_rdata(cp0_rdata), .epc_out(epc_out),
    .exc_vec(exc_vec), .int_req(int_req)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    valid_m = 0; bd_m = 0; pc_m = '0; exc_code_m = '0; hw_int = '0;
    cp0_we = 0; cp0_addr = '0; cp0_wdata = '0; eret_m = 0;
  endtask

  task automatic want(input string n, input logic [31:0] v);
    want_q.push_back('{n, v});
  endtask

  task automatic snap(input string n, input logic [4:0] a);
    cp0_addr = a;
    #1;
    got_q.push_back('{n, cp0_rdata});
  endtask

  task automatic snap_irq(input string n);
    #1;
    got_q.push_back('{n, {31'b0, int_req}});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1; cp0_addr = a; cp0_wdata = d; valid_m = 1;
    step();
    idle();
  endtask

  task automatic test_reset();
    repeat (2) step();
    reset = 0;
    step();
    want("rst_irq", 0); snap_irq("rst_irq");
    want("rst_sr", 0); snap("rst_sr", 12);
    want("rst_cause", 0); snap("rst_cause", 13);
    want("rst_epc", 0); snap("rst_epc", 14);
    want("rst_prid", 32'h2019_0701); snap("rst_prid", 15);
    want("rst_vec", 32'h0000_4180); got_q.push_back('{"rst_vec", exc_vec});
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  task automatic test_irq_entry();
    mtc0(12, 32'h0000_FC01);
    want("t1_sr", 32'h0000_FC01); snap("t1_sr", 12);
    hw_int = 6'b000001; valid_m = 1; pc_m = 32'h3010;
    want("t1_irq", 1); snap_irq("t1_irq");
    step();
    idle();
    want("t1_epc", 32'h3010); snap("t1_epc", 14);
    want("t1_cause", 32'h0000_0400); snap("t1_cause", 13);
    want("t1_sr_exl", 32'h0000_FC03); snap("t1_sr_exl", 12);
    want("t1_epc_out", 32'h3010); got_q.push_back('{"t1_epc_out", epc_out});
    eret_m = 1; valid_m = 1;
    step();
    idle();
    want("t1_eret_sr", 32'h0000_FC01); snap("t1_eret_sr", 12);
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  task automatic test_exc_bd();
    mtc0(12, 32'h0000_FC00);
    exc_code_m = 12; bd_m = 1; pc_m = 32'h3024; valid_m = 1;
    want("t2_irq", 1); snap_irq("t2_irq");
    step();
    idle();
    want("t2_cause", 32'h8000_0030); snap("t2_cause", 13);
    want("t2_epc", 32'h3020); snap("t2_epc", 14);
    want("t2_sr", 32'h0000_FC02); snap("t2_sr", 12);
    eret_m = 1; valid_m = 1;
    step();
    idle();
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  task automatic test_priority();
    mtc0(12, 32'h0000_1001);
    hw_int = 6'b000100; exc_code_m = 10; valid_m = 1; pc_m = 32'h3040;
    cp0_we = 1; cp0_addr = 14; cp0_wdata = 32'h5000;
    want("t3_irq", 1); snap_irq("t3_irq");
    step();
    idle();
    want("t3_cause", 32'h0000_1000); snap("t3_cause", 13);
    want("t3_epc", 32'h3040); snap("t3_epc", 14);
    want("t3_sr", 32'h0000_1003); snap("t3_sr", 12);
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  task automatic test_exl_mask_eret();
    hw_int = 6'b000100; exc_code_m = 4; valid_m = 1;
    want("t4_masked", 0); snap_irq("t4_masked");
    step();
    exc_code_m = 0; eret_m = 1;
    want("t4_eret_cyc", 0); snap_irq("t4_eret_cyc");
    step();
    eret_m = 0;
    want("t4_sr", 32'h0000_1001); snap("t4_sr", 12);
    want("t4_irq", 1); snap_irq("t4_irq");
    valid_m = 0;
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  task automatic test_bubble_read();
    hw_int = 6'b000100; valid_m = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      want($sformatf("t5_bubble%0d", i), 0); snap_irq($sformatf("t5_bubble%0d", i));
    end
    valid_m = 1;
    want("t5_valid", 1); snap_irq("t5_valid");
    valid_m = 0;
    want("t5_prid", 32'h2019_0701); snap("t5_prid", 15);
    want("t5_cause_a", 32'h0000_1000); snap("t5_cause_a", 13);
    hw_int = 6'b100000;
    want("t5_cause_b", 32'h0000_1000); snap("t5_cause_b", 13);
    step();
    want("t5_cause_c", 32'h0000_8000); snap("t5_cause_c", 13);
    want("t5_other", 0); snap("t5_other", 3);
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  task automatic test_async_reset();
    hw_int = 6'b000100; valid_m = 1; pc_m = 32'h3100;
    want("t6_irq", 1); snap_irq("t6_irq");
    step();
    idle();
    want("t6_sr", 32'h0000_1003); snap("t6_sr", 12);
    want("t6_epc", 32'h3100); snap("t6_epc", 14);
    hw_int = 6'b000100; valid_m = 1;
    #2 reset = 1;
    want("t6_rst_irq", 0); snap_irq("t6_rst_irq");
    want("t6_rst_sr", 0); snap("t6_rst_sr", 12);
    want("t6_rst_cause", 0); snap("t6_rst_cause", 13);
    want("t6_rst_epc", 0); snap("t6_rst_epc", 14);
    idle();
    step();
    reset = 0;
    while (want_q.size() > 0) begin
      e = want_q.pop_front(); o = got_q.pop_front(); tests++;
      if (o.v !== e.v) begin fails++; $display("FAIL %s: got %h expected %h", e.n, o.v, e.v); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_irq_entry();
    test_exc_bd();
    test_priority();
    test_exl_mask_eret();
    test_bubble_read();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
